// File: rtl/rca4_frame_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rca4_frame_acc_pkg
//  Description : Shared types and constants for the rca4 frame accumulator.
//                Provides the frame FSM state enum, the accumulator width and
//                the saturation value used by the optional saturating build.
//  Revision    : 1.0  initial release
// ============================================================================
package rca4_frame_acc_pkg;

    localparam int ACC_W = 4;
    localparam logic [ACC_W-1:0] ACC_MAX = 4'hF;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage : rca4_frame_acc_pkg
`default_nettype wire

// File: rtl/rca4.sv
`default_nettype none
// ============================================================================
//  Module      : rca4
//  Description : 4-bit combinational ripple-carry adder built from four full
//                adders.
//  Ports       : a, b  - 4-bit addends
//                ci    - carry in
//                s     - 4-bit sum
//                co    - carry out of bit 3
//  Revision    : 1.0  initial release
// ============================================================================
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end

    assign co = w_c[4];

endmodule : rca4
`default_nettype wire

// File: rtl/rca4_frame_acc.sv
`default_nettype none
// ============================================================================
//  Module      : rca4_frame_acc
//  Description : Streaming frame accumulator. Sums NUM_OPS 4-bit operands per
//                frame through one rca4 (carry-in tied low), counts carry-out
//                events in a saturating counter and holds the result on a
//                valid/ready output until it is taken.
//  Parameters  : NUM_OPS - operands per frame (>= 1)
//                OVF_W   - width of the carry-event counter
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid/in_ready    - operand handshake
//                in_data              - 4-bit unsigned operand
//                out_valid/out_ready  - result handshake
//                out_sum              - frame sum
//                out_carries          - saturating carry-out count
//  Build macro : RCA4_FRAME_ACC_SAT_EN - sum saturates at 4'hF on carry-out
//                instead of wrapping modulo 16.
//  Revision    : 1.0  initial release
// ============================================================================
module rca4_frame_acc
    import rca4_frame_acc_pkg::*;
#(
    parameter int NUM_OPS = 8,
    parameter int OVF_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sum,
    output logic [OVF_W-1:0] out_carries
);

    localparam int CNT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NUM_OPS - 1);
    localparam logic [OVF_W-1:0] c_ccnt_max = {OVF_W{1'b1}};

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [OVF_W-1:0]   r_ccnt;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_co;
    logic               w_accept;
    logic               w_release;

    rca4 u_rca4 (
        .a  (r_acc),
        .b  (in_data),
        .ci (1'b0),
        .s  (w_sum),
        .co (w_co)
    );

`ifdef RCA4_FRAME_ACC_SAT_EN
    // Any carry-out means the true sum exceeded 15; pin the sum at full scale.
    assign w_acc_next = w_co ? ACC_MAX : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    // Handshake outputs depend only on the state register, so neither ready
    // has a combinational path from in_valid or out_ready.
    assign in_ready    = (r_state == ACCUM);
    assign out_valid   = (r_state == DONE);
    assign out_sum     = r_acc;
    assign out_carries = r_ccnt;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ACCUM: begin
                w_accept = in_valid;
                if (in_valid && (r_cnt == c_cnt_last)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_release = out_ready;
                if (out_ready) begin
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ccnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_co && (r_ccnt != c_ccnt_max)) begin
                r_ccnt <= r_ccnt + OVF_W'(1);
            end
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_release) begin
            // Counter was already cleared on the last accept of the frame.
            r_acc  <= '0;
            r_ccnt <= '0;
        end
    end

endmodule : rca4_frame_acc
`default_nettype wire

// File: tb/tb_rca4_frame_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca4_frame_acc
//  Description : Self-checking bench for rca4_frame_acc. Three instances
//                (NUM_OPS/OVF_W = 4/4, 8/2, 1/4) share one input stream and
//                are each compared every cycle against a frame-level model.
//  Build macro : RCA4_FRAME_ACC_SAT_EN selects the saturating sum model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rca4_frame_acc;

`ifdef RCA4_FRAME_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int NOPS [3] = '{4, 8, 1};
    localparam int WID  [3] = '{4, 2, 4};

    logic       clk;
    logic       rst;
    logic       iv;
    logic [3:0] id;
    logic       ordy;

    logic [2:0] irdy;
    logic [2:0] ov;
    logic [3:0] osum [3];
    logic [3:0] oc0;
    logic [1:0] oc1;
    logic [3:0] oc2;

    int checks   = 0;
    int failures = 0;

    // Frame-level model: operands accepted so far in the current frame.
    int ops  [3][8];
    int nacc [3];

    rca4_frame_acc #(.NUM_OPS(4), .OVF_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(irdy[0]), .in_data(id),
        .out_valid(ov[0]), .out_ready(ordy), .out_sum(osum[0]), .out_carries(oc0)
    );
    rca4_frame_acc #(.NUM_OPS(8), .OVF_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(irdy[1]), .in_data(id),
        .out_valid(ov[1]), .out_ready(ordy), .out_sum(osum[1]), .out_carries(oc1)
    );
    rca4_frame_acc #(.NUM_OPS(1), .OVF_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(irdy[2]), .in_data(id),
        .out_valid(ov[2]), .out_ready(ordy), .out_sum(osum[2]), .out_carries(oc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int carries_of(input int k);
        case (k)
            0:       return int'(oc0);
            1:       return int'(oc1);
            default: return int'(oc2);
        endcase
    endfunction

    // Plain arithmetic fold of the accepted operands.
    function automatic void fold(input int k, output int s, output int c);
        int t;
        s = 0;
        c = 0;
        for (int i = 0; i < NOPS[k]; i++) begin
            t = s + ops[k][i];
            if (t > 15) begin
                c++;
                s = SAT ? 15 : t - 16;
            end else begin
                s = t;
            end
        end
        if (c > (1 << WID[k]) - 1) c = (1 << WID[k]) - 1;
    endfunction

    // One clock: update the model with the inputs seen at the edge, then
    // compare every instance on the falling edge.
    task automatic tick();
        int s, c;
        bit erdy;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            erdy = (nacc[k] < NOPS[k]);
            if (rst) nacc[k] = 0;
            else if (erdy && iv) begin
                ops[k][nacc[k]] = int'(id);
                nacc[k]++;
            end else if (!erdy && ordy) nacc[k] = 0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            erdy = (nacc[k] < NOPS[k]);
            check($sformatf("in_ready%0d", k), int'(irdy[k]), int'(erdy));
            check($sformatf("out_valid%0d", k), int'(ov[k]), int'(!erdy));
            if (!erdy) begin
                fold(k, s, c);
                check($sformatf("out_sum%0d", k), int'(osum[k]), s);
                check($sformatf("out_carries%0d", k), carries_of(k), c);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; id = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_sum", int'(osum[0]), 0);
        check("rst_carries", carries_of(0), 0);
    endtask

    task automatic send(input int v);
        iv = 1'b1;
        id = 4'(v);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) nacc[k] = 0;
        rst = 1'b1; iv = 1'b0; id = 4'h0; ordy = 1'b0;
        @(negedge clk);
        do_reset();

        // 1,2,3,4 back-to-back
        ordy = 1'b1;
        send(1); send(2); send(3); send(4);
        check("sum_1234", int'(osum[0]), 10);
        check("carries_1234", carries_of(0), 0);
        check("valid_1234", int'(ov[0]), 1);
        iv = 1'b0;
        tick();
        check("valid_single", int'(ov[0]), 0);

        // F,F,F,F
        do_reset();
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) send(15);
        check("sum_ffff", int'(osum[0]), SAT ? 15 : 12);
        check("carries_ffff", carries_of(0), 3);

        // eight F then eight 0 on the 8-op, 2-bit-counter instance
        do_reset();
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) send(15);
        check("carries_sat", carries_of(1), 3);
        check("sum_8f", int'(osum[1]), SAT ? 15 : 8);
        iv = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) send(0);
        check("sum_8z", int'(osum[1]), 0);
        check("carries_8z", carries_of(1), 0);

        // backpressure
        do_reset();
        ordy = 1'b0;
        send(1); send(2); send(3); send(4);
        iv = 1'b1; id = 4'h5;
        for (int i = 0; i < 5; i++) tick();
        check("bp_held", int'(ov[0]), 1);
        ordy = 1'b1;
        tick();
        check("bp_ready_after", int'(irdy[0]), 1);
        tick();

        // in_valid toggling 1,0,0,1,0,1,1 with operands 2,3,4,5
        do_reset();
        ordy = 1'b1;
        send(2);
        iv = 1'b0; tick(); tick();
        send(3);
        iv = 1'b0; tick();
        send(4); send(5);
        check("sum_toggle", int'(osum[0]), 14);

        // reset mid-frame, then a clean frame
        do_reset();
        send(7); send(7);
        rst = 1'b1; iv = 1'b0;
        tick();
        rst = 1'b0;
        send(1); send(1); send(1); send(1);
        check("sum_after_rst", int'(osum[0]), 4);
        check("carries_after_rst", carries_of(0), 0);

        // reset while holding a result
        ordy = 1'b0; iv = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_done", int'(ov[0]), 0);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            id   = 4'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 2) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rca4_frame_acc
`default_nettype wire
